// File: rtl/ram_ctrl_if.sv
// Word-access memory bus between a cache/test master and ram_ctrl.
interface ram_ctrl_if;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;

  logic              data_stb;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_din;
  logic [DATA_W-1:0] data_dout;
  logic              data_ack;
  logic              data_timeout;

  modport master (
    output data_stb,
    output data_we,
    output data_addr,
    output data_din,
    input  data_dout,
    input  data_ack,
    input  data_timeout
  );

  modport slave (
    input  data_stb,
    input  data_we,
    input  data_addr,
    input  data_din,
    output data_dout,
    output data_ack,
    output data_timeout
  );
endinterface

// File: rtl/ram_ctrl.sv
// SDRAM-like memory controller model: power-up init delay, fixed access
// latencies, periodic refresh stalls and a request timeout for bus liveness.
module ram_ctrl #(
  parameter int unsigned MEM_AW         = 16,
  parameter int unsigned INIT_CYCLES    = 20000,
  parameter int unsigned RD_LATENCY     = 5,
  parameter int unsigned WR_LATENCY     = 3,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REFRESH_CYCLES = 7,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        clk_ok,
  ram_ctrl_if.slave   bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);
  localparam int unsigned REF_W   = $clog2(REFRESH_PERIOD + 1);
  localparam int unsigned RCYC_W  = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_REFRESH
  } state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [REF_W-1:0]    ref_cnt;
  logic [RCYC_W-1:0]   rcyc_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                ref_pend;

  logic                we_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W-1:0]   dout_q;
  logic                ack_q;
  logic                tout_q;

  logic [DATA_W-1:0]   mem [2**MEM_AW];

  logic                in_range;
  logic [LAT_W-1:0]    lat_tgt;
  logic                acc_done;
  logic                to_hit;
  logic                can_accept;
  logic                ref_due;
  logic                ref_enter;

  // Request qualification, access completion and timeout detection.
  always_comb begin
    in_range   = (bus.data_addr[26:MEM_AW] == '0);
    lat_tgt    = we_q ? LAT_W'(WR_LATENCY - 1) : LAT_W'(RD_LATENCY - 1);
    acc_done   = (state == S_ACCESS) && (lat_cnt == lat_tgt);
    to_hit     = bus.data_stb && !acc_done && (to_cnt == TO_W'(TIMEOUT - 1));
    can_accept = bus.data_stb && in_range && !to_hit;
    ref_due    = (state != S_INIT) && (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
    ref_enter  = (state == S_IDLE) && ref_pend;
  end

  // Controller FSM with timeout and refresh bookkeeping; all outputs registered.
  always_ff @(posedge clk or negedge clk_ok) begin
    if (!clk_ok) begin
      state    <= S_INIT;
      init_cnt <= '0;
      lat_cnt  <= '0;
      ref_cnt  <= '0;
      rcyc_cnt <= '0;
      to_cnt   <= '0;
      ref_pend <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      ack_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      tout_q <= to_hit;

      // A pending strobe ages until it is acked, times out, or is dropped.
      if (!bus.data_stb || acc_done || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      // Refresh timer free-runs once init is over.
      if (state != S_INIT) begin
        ref_cnt <= ref_due ? '0 : ref_cnt + 1'b1;
      end
      ref_pend <= ref_due | (ref_pend & !ref_enter);

      case (state)
        S_INIT: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (ref_pend) begin
            state    <= S_REFRESH;
            rcyc_cnt <= '0;
          end else if (can_accept) begin
            state   <= S_ACCESS;
            lat_cnt <= '0;
            we_q    <= bus.data_we;
            addr_q  <= bus.data_addr[MEM_AW-1:0];
            din_q   <= bus.data_din;
          end
        end

        S_ACCESS: begin
          if (acc_done) begin
            state <= S_IDLE;
            ack_q <= 1'b1;
            if (!we_q) begin
              dout_q <= mem[addr_q];
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        S_REFRESH: begin
          // The last blocked cycle hands over directly so a refresh costs
          // exactly REFRESH_CYCLES of extra latency.
          if (rcyc_cnt == RCYC_W'(REFRESH_CYCLES - 1)) begin
            if (can_accept) begin
              state   <= S_ACCESS;
              lat_cnt <= '0;
              we_q    <= bus.data_we;
              addr_q  <= bus.data_addr[MEM_AW-1:0];
              din_q   <= bus.data_din;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            rcyc_cnt <= rcyc_cnt + 1'b1;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

  // Backing store; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_done && we_q) begin
      mem[addr_q] <= din_q;
    end
  end

  assign bus.data_dout    = dout_q;
  assign bus.data_ack     = ack_q;
  assign bus.data_timeout = tout_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: init timeout, table of basic accesses,
// pattern fill, out-of-range timeouts, refresh stall and mid-access reset.
module tb_ram_ctrl;

  localparam int unsigned INIT_CYCLES = 20000;
  localparam int unsigned RD_LAT      = 5;
  localparam int unsigned WR_LAT      = 3;
  localparam int unsigned REF_CYC     = 7;
  localparam int unsigned TIMEOUT     = 64;
  localparam int          RD_OBS      = RD_LAT + 1;
  localparam int          WR_OBS      = WR_LAT + 1;

  logic clk    = 1'b0;
  logic clk_ok = 1'b0;

  ram_ctrl_if bus ();

  ram_ctrl dut (
    .clk    (clk),
    .clk_ok (clk_ok),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [26:0] addr;
    logic [31:0] din;
    logic [1:0]  exp_resp;   // {ack, timeout}
    int          exp_lat;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a posedge+1 phase; returns at the response cycle.
  task automatic do_req(input logic we, input logic [26:0] addr, input logic [31:0] din,
                        output logic [1:0] resp, output int lat, output logic [31:0] dout);
    bus.data_we   = we;
    bus.data_addr = addr;
    bus.data_din  = din;
    bus.data_stb  = 1'b1;
    resp = 2'b00;
    lat  = 0;
    while (resp == 2'b00 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      resp = {bus.data_ack, bus.data_timeout};
    end
    dout = bus.data_dout;
    bus.data_stb = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    int          lat;
    logic [31:0] dout;
    int          first_to;
    int          n_to;
    int          n_ack;
    int          guard;
    int          cyc;
    int          nrd;
    int          delayed;
    logic [26:0] a;

    vecs[0]  = '{1'b1, 27'd5,         32'hDEADBEEF, 2'b10, WR_OBS,  32'h0000_0000};
    vecs[1]  = '{1'b0, 27'd5,         32'h0,        2'b10, RD_OBS,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 27'd0,         32'h12345678, 2'b10, WR_OBS,  32'hDEADBEEF};
    vecs[3]  = '{1'b1, 27'h000FFFF,   32'hA5A5F00F, 2'b10, WR_OBS,  32'hDEADBEEF};
    vecs[4]  = '{1'b0, 27'h000FFFF,   32'h0,        2'b10, RD_OBS,  32'hA5A5F00F};
    vecs[5]  = '{1'b0, 27'd0,         32'h0,        2'b10, RD_OBS,  32'h12345678};
    vecs[6]  = '{1'b0, 27'h4000000,   32'h0,        2'b01, TIMEOUT, 32'h12345678};
    vecs[7]  = '{1'b0, 27'h0010000,   32'h0,        2'b01, TIMEOUT, 32'h12345678};
    vecs[8]  = '{1'b1, 27'h7FFFFFF,   32'h55555555, 2'b01, TIMEOUT, 32'h12345678};
    vecs[9]  = '{1'b0, 27'd5,         32'h0,        2'b10, RD_OBS,  32'hDEADBEEF};
    vecs[10] = '{1'b1, 27'd5,         32'hCAFEF00D, 2'b10, WR_OBS,  32'hDEADBEEF};
    vecs[11] = '{1'b0, 27'd5,         32'h0,        2'b10, RD_OBS,  32'hCAFEF00D};

    bus.data_stb  = 1'b0;
    bus.data_we   = 1'b0;
    bus.data_addr = '0;
    bus.data_din  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  32'(bus.data_ack), 32'd0);
    check("rst_tout", 32'(bus.data_timeout), 32'd0);
    check("rst_dout", bus.data_dout, 32'd0);

    // Strobe during INIT: one timeout after TIMEOUT cycles, never an ack.
    @(negedge clk);
    clk_ok = 1'b1;
    bus.data_stb = 1'b1;
    first_to = 0;
    n_to = 0;
    n_ack = 0;
    for (int k = 1; k <= int'(INIT_CYCLES) + 2; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_ack) n_ack++;
      if (bus.data_timeout) begin
        n_to++;
        if (first_to == 0) first_to = k;
        bus.data_stb = 1'b0;
      end
    end
    check("init_to_cycle", 32'(first_to), 32'(TIMEOUT));
    check("init_to_count", 32'(n_to), 32'd1);
    check("init_no_ack",   32'(n_ack), 32'd0);
    check("init_dout",     bus.data_dout, 32'd0);

    // Basic accesses and out-of-range timeouts, exact latencies.
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].din, resp, lat, dout);
      check($sformatf("v%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      check($sformatf("v%0d_lat", i),  32'(lat),  32'(vecs[i].exp_lat));
      check($sformatf("v%0d_dout", i), dout,      vecs[i].exp_dout);
    end

    // Pattern fill and readback; refresh may add up to REF_CYC cycles.
    for (int i = 0; i < 1024; i++) begin
      a = 27'(i);
      do_req(1'b1, a, ~32'(i), resp, lat, dout);
      check($sformatf("fill_wr_%0d", i),
            32'(resp == 2'b10 && lat >= WR_OBS && lat <= WR_OBS + int'(REF_CYC)), 32'd1);
    end
    for (int i = 0; i < 1024; i++) begin
      a = 27'(i);
      do_req(1'b0, a, 32'h0, resp, lat, dout);
      check($sformatf("fill_rd_%0d", i),
            32'(resp == 2'b10 && lat >= RD_OBS && lat <= RD_OBS + int'(REF_CYC)), 32'd1);
      check($sformatf("fill_data_%0d", i), dout, ~32'(i));
    end

    // Back-to-back reads, strobe held high across acks and a refresh.
    bus.data_we   = 1'b0;
    bus.data_addr = 27'd100;
    bus.data_stb  = 1'b1;
    nrd = 0;
    cyc = 0;
    guard = 0;
    delayed = 0;
    n_to = 0;
    while (nrd < 150 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
      cyc++;
      if (bus.data_timeout) n_to++;
      if (bus.data_ack) begin
        check($sformatf("b2b_data_%0d", nrd), bus.data_dout, ~32'(100 + nrd));
        if (cyc != RD_OBS) delayed++;
        check($sformatf("b2b_lat_%0d", nrd),
              32'(cyc == RD_OBS || cyc == RD_OBS + int'(REF_CYC)), 32'd1);
        nrd++;
        cyc = 0;
        bus.data_addr = 27'(100 + nrd);
      end
    end
    bus.data_stb = 1'b0;
    check("b2b_done",    32'(nrd), 32'd150);
    check("b2b_no_tout", 32'(n_to), 32'd0);
    check("b2b_refresh", 32'(delayed >= 1 && delayed <= 2), 32'd1);

    // Reset in the middle of a write.
    do_req(1'b0, 27'd7, 32'h0, resp, lat, dout);
    check("pre_rst_rd", dout, ~32'd7);
    bus.data_we   = 1'b1;
    bus.data_addr = 27'd2000;
    bus.data_din  = 32'h11111111;
    bus.data_stb  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    clk_ok = 1'b0;
    #1;
    check("midrst_ack",  32'(bus.data_ack), 32'd0);
    check("midrst_tout", 32'(bus.data_timeout), 32'd0);
    check("midrst_dout", bus.data_dout, 32'd0);
    bus.data_stb = 1'b0;
    @(negedge clk);
    clk_ok = 1'b1;
    @(posedge clk);
    #1;
    n_ack = 0;
    for (int k = 0; k < int'(INIT_CYCLES) - 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_ack) n_ack++;
    end
    check("reinit_no_ack", 32'(n_ack), 32'd0);
    do_req(1'b0, 27'd7, 32'h0, resp, lat, dout);
    check("reinit_resp", 32'(resp), 32'(2'b01));
    check("reinit_lat",  32'(lat),  32'(TIMEOUT));
    repeat (200) @(posedge clk);
    #1;
    do_req(1'b0, 27'd7, 32'h0, resp, lat, dout);
    check("keep_rd7_resp", 32'(resp), 32'(2'b10));
    check("keep_rd7_data", dout, ~32'd7);
    do_req(1'b0, 27'd1023, 32'h0, resp, lat, dout);
    check("keep_rd1023_resp", 32'(resp), 32'(2'b10));
    check("keep_rd1023_data", dout, ~32'd1023);
    do_req(1'b0, 27'd2000, 32'h0, resp, lat, dout);
    check("post_abort_rd_resp", 32'(resp), 32'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
